// File: rtl/i2c_reg_seq.sv
// i2c_reg_seq: single-register read/write sequencer sitting on top of a
// byte-level I2C master.
//
// A write issues START, {dev,W}, reg, data, STOP.
// A read issues START, {dev,W}, reg, STOP, START, {dev,R}, then one byte
// read with a paired stop, which makes the master NACK and stop.
//
// Ports:
//   iClk, iRst_n                 clock (rising edge), async active-low reset
//   iReq, iRw, iDev_Addr,        transaction request and its fields; the
//   iReg_Addr, iWr_Data          fields are captured on accept in IDLE
//   oBusy, oDone, oNack,         transaction status
//   oRd_Data                     and read result
//   oI2C_Start                   level to the master's start input
//   oI2C_Stop/Write/Read         one-cycle command pulses to the master
//   oTx_Data                     byte presented to the master
//   iTx_Done, iTx_Ready,         master handshake
//   iRx_Data, iRx_Done           received byte
module i2c_reg_seq #(
  parameter int ACK_WAIT = 4
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iReq,
  input  logic       iRw,
  input  logic [6:0] iDev_Addr,
  input  logic [7:0] iReg_Addr,
  input  logic [7:0] iWr_Data,
  output logic       oBusy,
  output logic       oDone,
  output logic       oNack,
  output logic [7:0] oRd_Data,
  output logic       oI2C_Start,
  output logic       oI2C_Stop,
  output logic       oI2C_Write,
  output logic       oI2C_Read,
  output logic [7:0] oTx_Data,
  input  logic       iTx_Done,
  input  logic       iTx_Ready,
  input  logic [7:0] iRx_Data,
  input  logic       iRx_Done
);

  localparam int CW = $clog2(ACK_WAIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_WAIT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(ACK_WAIT);

  typedef enum logic [3:0] {
    IDLE, ST_ADDR, ACK_CHK, WR_REG, WR_DAT, RD_STOP, RST_ADDR, RD_BYTE, STOP, DONE
  } state_t;

  // Which byte the pending ACK belongs to; selects the exit from ACK_CHK.
  typedef enum logic [1:0] {
    PH_ADDR_W, PH_REG, PH_DATA, PH_ADDR_R
  } phase_t;

  state_t          state_q,  state_d;
  phase_t          phase_q,  phase_d;
  logic [CW-1:0]   cnt_q,    cnt_d;
  logic            issued_q, issued_d;
  logic            rw_q,     rw_d;
  logic [6:0]      dev_q,    dev_d;
  logic [7:0]      reg_q,    reg_d;
  logic [7:0]      wdat_q,   wdat_d;
  logic [7:0]      tx_q,     tx_d;
  logic [7:0]      rd_q,     rd_d;
  logic            nack_q,   nack_d;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q  <= IDLE;
      phase_q  <= PH_ADDR_W;
      cnt_q    <= '0;
      issued_q <= 1'b0;
      rw_q     <= 1'b0;
      dev_q    <= '0;
      reg_q    <= '0;
      wdat_q   <= '0;
      tx_q     <= '0;
      rd_q     <= '0;
      nack_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      issued_q <= issued_d;
      rw_q     <= rw_d;
      dev_q    <= dev_d;
      reg_q    <= reg_d;
      wdat_q   <= wdat_d;
      tx_q     <= tx_d;
      rd_q     <= rd_d;
      nack_q   <= nack_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    issued_d   = issued_q;
    rw_d       = rw_q;
    dev_d      = dev_q;
    reg_d      = reg_q;
    wdat_d     = wdat_q;
    tx_d       = tx_q;
    rd_d       = rd_q;
    nack_d     = nack_q;
    oI2C_Start = 1'b0;
    oI2C_Stop  = 1'b0;
    oI2C_Write = 1'b0;
    oI2C_Read  = 1'b0;
    oDone      = 1'b0;

    case (state_q)
      IDLE: begin
        if (iReq) begin
          rw_d    = iRw;
          dev_d   = iDev_Addr;
          reg_d   = iReg_Addr;
          wdat_d  = iWr_Data;
          nack_d  = 1'b0;
          tx_d    = {iDev_Addr, 1'b0};
          phase_d = PH_ADDR_W;
          state_d = ST_ADDR;
        end
      end

      // Start is a level: the master only samples it once idle, which may be
      // well after we raise it (e.g. while it is still finishing a stop).
      ST_ADDR, RST_ADDR: begin
        oI2C_Start = 1'b1;
        if (iTx_Done) begin
          cnt_d   = '0;
          state_d = ACK_CHK;
        end
      end

      // The master returns to HOLD (iTx_Ready) only after a slave ACK; on a
      // NACK it stops the bus by itself, so no stop is issued from here.
      ACK_CHK: begin
        if (iTx_Ready) begin
          case (phase_q)
            PH_ADDR_W: begin
              tx_d    = reg_q;
              phase_d = PH_REG;
              state_d = WR_REG;
            end
            PH_REG: begin
              if (rw_q) begin
                state_d = RD_STOP;
              end else begin
                tx_d    = wdat_q;
                phase_d = PH_DATA;
                state_d = WR_DAT;
              end
            end
            PH_DATA:   state_d = STOP;
            default:   state_d = RD_BYTE;
          endcase
        end else if (cnt_q == CNT_LAST) begin
          nack_d  = 1'b1;
          state_d = DONE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // issued_q separates "waiting to send the write" from "waiting for the
      // byte to finish", so the write pulse is exactly one clock.
      WR_REG, WR_DAT: begin
        if (!issued_q) begin
          if (iTx_Ready) begin
            oI2C_Write = 1'b1;
            issued_d   = 1'b1;
          end
        end else if (iTx_Done) begin
          issued_d = 1'b0;
          cnt_d    = '0;
          state_d  = ACK_CHK;
        end
      end

      RD_STOP: begin
        if (iTx_Ready) begin
          oI2C_Stop = 1'b1;
          tx_d      = {dev_q, 1'b1};
          phase_d   = PH_ADDR_R;
          state_d   = RST_ADDR;
        end
      end

      // Read paired with stop: the master NACKs the single byte and stops.
      RD_BYTE: begin
        if (!issued_q) begin
          if (iTx_Ready) begin
            oI2C_Read = 1'b1;
            oI2C_Stop = 1'b1;
            issued_d  = 1'b1;
          end
        end else if (iRx_Done) begin
          rd_d     = iRx_Data;
          issued_d = 1'b0;
          state_d  = DONE;
        end
      end

      STOP: begin
        if (iTx_Ready) begin
          oI2C_Stop = 1'b1;
          state_d   = DONE;
        end
      end

      DONE: begin
        oDone   = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign oBusy    = (state_q != IDLE) && (state_q != DONE);
  assign oNack    = nack_q;
  assign oRd_Data = rd_q;
  assign oTx_Data = tx_q;

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Bench for i2c_reg_seq: a behavioural I2C master + slave drives the master
// handshake and logs every bus event; each transaction's log is compared with
// the event list expected for that request.
`timescale 1ns/1ps
module tb_i2c_reg_seq;
  localparam int ACK_WAIT = 4;
  localparam int EV_START = 32'h100;
  localparam int EV_STOP  = 32'h200;
  localparam int EV_RD    = 32'h400;

  localparam int M_IDLE = 0, M_XFER = 1, M_ACKD = 2, M_RDLY = 3, M_HOLD = 4,
                 M_RD = 5, M_STOPPING = 6, M_ASTOP = 7;

  logic       clk = 1'b0;
  logic       iRst_n, iReq, iRw;
  logic [6:0] iDev_Addr;
  logic [7:0] iReg_Addr, iWr_Data;
  logic       oBusy, oDone, oNack;
  logic [7:0] oRd_Data;
  logic       oI2C_Start, oI2C_Stop, oI2C_Write, oI2C_Read;
  logic [7:0] oTx_Data;
  logic       iTx_Done, iTx_Ready, iRx_Done;
  logic [7:0] iRx_Data;

  always #5 clk = ~clk;

  i2c_reg_seq #(.ACK_WAIT(ACK_WAIT)) dut (
    .iClk(clk), .iRst_n(iRst_n), .iReq(iReq), .iRw(iRw),
    .iDev_Addr(iDev_Addr), .iReg_Addr(iReg_Addr), .iWr_Data(iWr_Data),
    .oBusy(oBusy), .oDone(oDone), .oNack(oNack), .oRd_Data(oRd_Data),
    .oI2C_Start(oI2C_Start), .oI2C_Stop(oI2C_Stop), .oI2C_Write(oI2C_Write),
    .oI2C_Read(oI2C_Read), .oTx_Data(oTx_Data),
    .iTx_Done(iTx_Done), .iTx_Ready(iTx_Ready),
    .iRx_Data(iRx_Data), .iRx_Done(iRx_Done)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared between the bench sequencer and the master/slave model.
  int         bus_q[$];
  int         nack_pos;       // 0: slave ACKs all; n: slave NACKs the n-th byte
  logic [7:0] slave_rd;
  int         m_bidx, m_st, m_cnt, m_r;
  int         excl_err = 0, rdy_err = 0, hold_err = 0, last_done_cyc = 0;
  logic [7:0] last_byte;
  logic       nx_done, nx_ready, nx_rxd;
  logic [7:0] nx_rxdat;
  int         npulse;

  task automatic send_byte();
    last_byte = oTx_Data;
    bus_q.push_back(int'(oTx_Data));
    m_bidx++;
    m_cnt = $urandom_range(1, 4);
    m_st  = M_XFER;
  endtask

  // Master + slave: inputs change at the falling edge, DUT outputs are
  // observed 4 ns later, just before the rising edge that consumes them.
  initial begin
    m_st = M_IDLE; m_cnt = 0; m_bidx = 0; last_byte = 8'h00;
    nx_done = 1'b0; nx_ready = 1'b0; nx_rxd = 1'b0; nx_rxdat = 8'h00;
    iTx_Done = 1'b0; iTx_Ready = 1'b0; iRx_Done = 1'b0; iRx_Data = 8'h00;
    forever begin
      @(negedge clk);
      iTx_Done = nx_done; iTx_Ready = nx_ready; iRx_Done = nx_rxd; iRx_Data = nx_rxdat;
      #4;
      if (!iRst_n) begin
        m_st = M_IDLE; nx_done = 1'b0; nx_ready = 1'b0; nx_rxd = 1'b0;
      end else begin
        npulse = int'(oI2C_Write) + int'(oI2C_Read) + int'(oI2C_Stop);
        if (npulse > 1 && !(oI2C_Read && oI2C_Stop && !oI2C_Write)) excl_err++;
        if (npulse > 0 && !iTx_Ready) rdy_err++;
        if (iTx_Done) begin
          last_done_cyc = cyc;
          if (oTx_Data !== last_byte) hold_err++;
        end
        nx_done = 1'b0; nx_rxd = 1'b0; nx_rxdat = 8'($urandom);
        case (m_st)
          M_IDLE: if (oI2C_Start) begin bus_q.push_back(EV_START); send_byte(); end
          M_XFER: if (m_cnt > 0) m_cnt--; else begin nx_done = 1'b1; m_st = M_ACKD; end
          M_ACKD: begin
            if (m_bidx == nack_pos) begin
              m_cnt = $urandom_range(0, 3); m_st = M_ASTOP;
            end else begin
              m_r = $urandom_range(0, ACK_WAIT - 1);
              if (m_r == 0) begin nx_ready = 1'b1; m_st = M_HOLD; end
              else begin m_cnt = m_r; m_st = M_RDLY; end
            end
          end
          M_RDLY: begin
            m_cnt--;
            if (m_cnt == 0) begin nx_ready = 1'b1; m_st = M_HOLD; end
          end
          M_HOLD: begin
            if (oI2C_Write) begin
              nx_ready = 1'b0; send_byte();
            end else if (oI2C_Read) begin
              bus_q.push_back(EV_RD | int'(slave_rd));
              bus_q.push_back(EV_STOP);
              nx_ready = 1'b0; m_cnt = $urandom_range(2, 6); m_st = M_RD;
            end else if (oI2C_Stop) begin
              bus_q.push_back(EV_STOP);
              nx_ready = 1'b0; m_cnt = $urandom_range(1, 5); m_st = M_STOPPING;
            end
          end
          M_RD: begin
            if (m_cnt > 0) m_cnt--;
            else begin
              nx_rxd = 1'b1; nx_rxdat = slave_rd;
              m_cnt = $urandom_range(1, 4); m_st = M_STOPPING;
            end
          end
          default: if (m_cnt > 0) m_cnt--; else m_st = M_IDLE;
        endcase
      end
    end
  end

  // Reference: expected bus events for one request.
  int         exp_q[$];
  logic [7:0] exp_rd = 8'h00;

  task automatic build_exp(input bit rw, input logic [6:0] dev, input logic [7:0] ra,
                           input logic [7:0] wd, input int np, input logic [7:0] rb);
    exp_q.delete();
    exp_q.push_back(EV_START);
    exp_q.push_back(int'({dev, 1'b0}));
    if (np == 1) return;
    exp_q.push_back(int'(ra));
    if (np == 2) return;
    if (!rw) begin
      exp_q.push_back(int'(wd));
      if (np == 3) return;
      exp_q.push_back(EV_STOP);
    end else begin
      exp_q.push_back(EV_STOP);
      exp_q.push_back(EV_START);
      exp_q.push_back(int'({dev, 1'b1}));
      if (np == 3) return;
      exp_q.push_back(EV_RD | int'(rb));
      exp_q.push_back(EV_STOP);
    end
  endtask

  task automatic issue_req(input bit rw, input logic [6:0] dev, input logic [7:0] ra,
                           input logic [7:0] wd, input int np, input logic [7:0] rb);
    nack_pos = np; slave_rd = rb; m_bidx = 0; bus_q.delete();
    build_exp(rw, dev, ra, wd, np, rb);
    @(negedge clk);
    iReq = 1'b1; iRw = rw; iDev_Addr = dev; iReg_Addr = ra; iWr_Data = wd;
    #3;
    chk("idle_not_busy", 32'(oBusy), 32'(0));
    chk("done_single_pulse", 32'(oDone), 32'(0));
    @(negedge clk);
    iReq = 1'b0; iRw = 1'($urandom); iDev_Addr = 7'($urandom);
    iReg_Addr = 8'($urandom); iWr_Data = 8'($urandom);
    #3;
    chk("busy_after_accept", 32'(oBusy), 32'(1));
  endtask

  task automatic do_txn(input bit rw, input logic [6:0] dev, input logic [7:0] ra,
                        input logic [7:0] wd, input int np, input logic [7:0] rb,
                        input bit poke);
    bit got;
    int busy_gap, k;
    issue_req(rw, dev, ra, wd, np, rb);
    got = 1'b0; busy_gap = 0; k = 0;
    while (!got && k < 400) begin
      @(negedge clk);
      iReq = poke && (k == 1);
      if (iReq) begin
        iRw = ~rw; iDev_Addr = dev ^ 7'h2A; iReg_Addr = ~ra; iWr_Data = ~wd;
      end
      #3;
      if (oDone) got = 1'b1;
      else if (!oBusy) busy_gap++;
      k++;
    end
    iReq = 1'b0;
    chk("done_seen", 32'(got), 32'(1));
    if (got) begin
      chk("busy_low_at_done", 32'(oBusy), 32'(0));
      chk("nack", 32'(oNack), 32'(np != 0));
      if (rw && np == 0) exp_rd = rb;
      chk("rd_data", 32'(oRd_Data), 32'(exp_rd));
      chk("busy_gap", 32'(busy_gap), 32'(0));
      chk("bus_len", 32'(bus_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
        chk("bus_event", (i < bus_q.size()) ? bus_q[i] : -1, exp_q[i]);
      if (np != 0) chk("nack_latency", 32'(cyc - last_done_cyc), 32'(ACK_WAIT + 1));
    end
  endtask

  task automatic reset_mid_write();
    int k, done_cnt;
    issue_req(1'b0, 7'h3B, 8'h21, 8'hC7, 0, 8'h00);
    k = 0;
    while (bus_q.size() < 4 && k < 400) begin
      @(negedge clk); #3; k++;
    end
    chk("reached_wr_dat", 32'(bus_q.size()), 32'(4));
    chk("tx_held_wr_dat", 32'(oTx_Data), 32'(8'hC7));
    @(negedge clk);
    #1 iRst_n = 1'b0;
    #1;
    chk("rst_all_outputs_zero",
        32'({oBusy, oDone, oNack, oRd_Data, oI2C_Start, oI2C_Stop, oI2C_Write,
             oI2C_Read, oTx_Data}), 32'(0));
    done_cnt = 0;
    repeat (3) begin
      @(negedge clk); #3;
      if (oDone) done_cnt++;
    end
    chk("no_done_in_reset", 32'(done_cnt), 32'(0));
    @(negedge clk);
    iRst_n = 1'b1;
    exp_rd = 8'h00;
    #3;
    chk("idle_after_reset", 32'(oBusy), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit rw;
    int np;
    iRst_n = 1'b0; iReq = 1'b0; iRw = 1'b0;
    iDev_Addr = 7'h00; iReg_Addr = 8'h00; iWr_Data = 8'h00;
    nack_pos = 0; slave_rd = 8'h00;
    #3;
    chk("reset_outputs",
        32'({oBusy, oDone, oNack, oRd_Data, oI2C_Start, oI2C_Stop, oI2C_Write,
             oI2C_Read, oTx_Data}), 32'(0));
    repeat (3) @(negedge clk);
    iRst_n = 1'b1;

    do_txn(1'b0, 7'h50, 8'h10, 8'hA5, 0, 8'h00, 1'b0);
    do_txn(1'b1, 7'h50, 8'h10, 8'h00, 0, 8'h3C, 1'b0);
    do_txn(1'b0, 7'h22, 8'h33, 8'h44, 1, 8'h00, 1'b0);
    do_txn(1'b0, 7'h31, 8'h05, 8'h77, 0, 8'h00, 1'b1);
    do_txn(1'b1, 7'h31, 8'h06, 8'h00, 0, 8'h5A, 1'b0);
    do_txn(1'b1, 7'h12, 8'h40, 8'h00, 3, 8'h99, 1'b0);
    reset_mid_write();
    do_txn(1'b0, 7'h3B, 8'h22, 8'h5E, 0, 8'h00, 1'b0);

    for (int t = 0; t < 40; t++) begin
      rw = 1'($urandom);
      np = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_txn(rw, 7'($urandom), 8'($urandom), 8'($urandom), np, 8'($urandom),
             1'($urandom));
    end

    chk("cmd_exclusive", 32'(excl_err), 32'(0));
    chk("cmd_only_when_ready", 32'(rdy_err), 32'(0));
    chk("tx_data_held", 32'(hold_err), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_reg_seq.md
I2C_REG_SEQ -- requirements
Module: i2c_reg_seq

Interface
REQ-001 SHALL have parameter ACK_WAIT, default 4, meaning the number of clocks after iTx_Done within which iTx_Ready must rise, else NACK.
REQ-002 SHALL have one clock and an asynchronous, active-low reset, with the clock as iClk and the reset as iRst_n.
REQ-003 SHALL have the following ports, one per line (name, direction, width, meaning):
- iClk  in  1  clock, rising edge
- iRst_n  in  1  asynchronous active-low reset
- iReq  in  1  one-cycle transaction request, sampled only in IDLE
- iRw  in  1  1 = register read, 0 = register write
- iDev_Addr  in  7  7-bit slave address
- iReg_Addr  in  8  register address
- iWr_Data  in  8  write payload
- oBusy  out  1  high from request accept until oDone
- oDone  out  1  one-cycle completion pulse
- oNack  out  1  status of last transaction, valid with oDone and held until the next accept
- oRd_Data  out  8  read result, updated only on a successful read
- oI2C_Start  out  1  level, to the master's start input
- oI2C_Stop  out  1  one-cycle pulse to the master
- oI2C_Write  out  1  one-cycle pulse to the master
- oI2C_Read  out  1  one-cycle pulse to the master
- oTx_Data  out  8  byte to the master, held stable from command issue to iTx_Done
- iTx_Done  in  1  byte plus slave-ACK phase complete
- iTx_Ready  in  1  master in HOLD, accepting commands
- iRx_Data  in  8  received byte, valid only while iRx_Done is high
- iRx_Done  in  1  read byte complete

Function
REQ-004 SHALL capture iRw, iDev_Addr, iReg_Addr and iWr_Data on accept (IDLE and iReq high); requests while busy are ignored.
REQ-005 SHALL implement the states IDLE, ST_ADDR, ACK_CHK, WR_REG, WR_DAT, RD_STOP, RST_ADDR, RD_BYTE, STOP, DONE.
REQ-006 ST_ADDR:
- oI2C_Start = 1 and oTx_Data = {dev, 0}.
- On iTx_Done, drop oI2C_Start and go to ACK_CHK.
- oI2C_Start is a level because the master samples start only when idle.
REQ-007 ACK_CHK:
- If iTx_Ready is seen within ACK_WAIT clocks (inclusive of the first ACK_CHK cycle), advance to the phase-dependent next state.
- Otherwise set oNack = 1 and go to DONE with no stop issued (the master auto-stops on NACK).
REQ-008 Next state after a successful ACK:
- addr-W phase -> WR_REG.
- reg phase -> WR_DAT on a write, RD_STOP on a read.
- data phase -> STOP.
- addr-R phase -> RD_BYTE.
REQ-009 WR_REG / WR_DAT:
- With iTx_Ready high, pulse oI2C_Write for 1 clock with oTx_Data = reg or data.
- Wait for iTx_Done, then go to ACK_CHK.
REQ-010 RD_STOP: with iTx_Ready high, pulse oI2C_Stop for 1 clock, then go to RST_ADDR.
REQ-011 RST_ADDR:
- Behaves as ST_ADDR with oTx_Data = {dev, 1}.
- Start is held through the master's stop sequence, and the master restarts as soon as it is idle.
REQ-012 RD_BYTE:
- With iTx_Ready high, pulse oI2C_Read and oI2C_Stop together for 1 clock (single byte, master NACKs and stops).
- On iRx_Done, load oRd_Data from iRx_Data and go to DONE.
REQ-013 STOP: with iTx_Ready high, pulse oI2C_Stop for 1 clock, then go to DONE.
REQ-014 DONE:
- oDone = 1 for one clock, oBusy drops the same clock, then return to IDLE.
- A new request may be accepted the following clock; its start waits on the master.
REQ-015 At most one of oI2C_Write, oI2C_Read and oI2C_Stop is high in any clock, except the RD_BYTE read+stop pair.
REQ-016 The ACK-wait counter SHALL be clog2(ACK_WAIT+1) bits, cleared on every ACK_CHK entry, and saturating.
REQ-017 A command pulse is issued only in a clock where iTx_Ready is high; otherwise the state waits indefinitely.

Reset
REQ-018 iRst_n low SHALL asynchronously force:
- state IDLE.
- all outputs 0, including oRd_Data = 0x00 and oTx_Data = 0x00.
- internal counters and captured fields 0.
REQ-019 Reset mid-transaction SHALL abort with no oDone pulse; the master shares the same reset, so the bus returns to idle.
REQ-020 The first request after reset release SHALL be accepted normally.

Verification
REQ-021 Write dev=0x50, reg=0x10, data=0xA5 with a slave model that ACKs all bytes -> bus carries START 0xA0 0x10 0xA5 STOP; oDone is one pulse; oNack = 0.
REQ-022 Read dev=0x50, reg=0x10 with the slave returning 0x3C -> bus carries START 0xA0 0x10 STOP START 0xA1 <0x3C, NACK> STOP; oRd_Data = 0x3C; oNack = 0.
REQ-023 Write to dev=0x22 with no slave (address NACK) -> oNack = 1 after ACK_WAIT clocks; no oI2C_Write or oI2C_Stop is issued; oRd_Data is unchanged.
REQ-024 iReq pulsed while busy, then a back-to-back request on the clock after oDone -> the first is ignored; the second starts only after the master reaches idle, and both complete.
REQ-025 iRst_n asserted during the WR_DAT byte -> all outputs are 0 immediately, no oDone pulse, and the next write completes normally.
